data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Parametrised data memory for the processor datapath; successor to the fixed 4-bit data memory.
//  Adds a valid/ready request port, a configurable registered read latency and a hardware clear sweep.
//  Sits between the CPU load/store unit and on-chip RAM, with one access accepted per cycle.
// PARAMETERS
//  DATA_W  8   word width in bits
//  ADDR_W  6   address width in bits
//  DEPTH   61  number of words; honoured only with DATA_MEM_BOUNDS_CHECK_EN, else forced to 2**ADDR_W
//  RD_LAT  1   read latency in cycles, legal range 1..4
// PORTS
//  clk        in   1       clock; every register updates on its rising edge
//  rst        in   1       synchronous reset, active-high
//  req_valid  in   1       access request
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  write data
//  req_ready  out  1       request accepted when req_valid & req_ready
//  rvalid     out  1       read data valid, one-cycle pulse per accepted read
//  rdata      out  DATA_W  read data; 0 when rvalid=0
//  rerr       out  1       out-of-range flag, qualified by rvalid
//  clr_start  in   1       start a clear sweep of the whole array
//  clr_done   out  1       one-cycle pulse when the sweep completes
// BEHAVIOUR
//  - Reset: state IDLE; rvalid, rdata, rerr, clr_done = 0; read pipeline flushed.
//    Array contents are NOT reset. req_ready = 0 while rst = 1.
//  - FSM has two states, IDLE and CLEAR. req_ready = (state == IDLE) & !rst.
//  - IDLE, clr_start = 1: go to CLEAR on the next edge.
//    Any request accepted in that same cycle still executes, before the sweep starts.
//  - CLEAR: a counter runs 0..DEPTH-1 and writes 0 to one word per cycle.
//    After writing word DEPTH-1 the FSM returns to IDLE. clr_done pulses in the first IDLE cycle,
//    which is also the cycle req_ready returns to 1. The sweep therefore takes DEPTH cycles.
//    clr_start is ignored while in CLEAR.
//  - Write: ram[req_addr] <= req_wdata on the accept edge. There is no response.
//  - Read: the array is sampled on the accept edge. rvalid/rdata appear RD_LAT cycles after the accept
//    edge (RD_LAT=1: visible in the cycle after the accept).
//  - Reads are delivered strictly in order, and back-to-back reads give back-to-back rvalid.
//  - A read accepted the cycle after a write to the same address returns the new data.
//  - Reads in flight when a sweep starts complete normally with their pre-clear data.
//  - Reset mid-sweep aborts it: no clr_done, and the uncleared words keep their contents.
//  - rdata is forced to 0 whenever rvalid = 0, including at the cycle rvalid falls.
// CONFIGURATION
//  - DATA_MEM_BOUNDS_CHECK_EN defined:
//    - array holds DEPTH words; req_addr >= DEPTH is out of range;
//    - out-of-range write: dropped, no state change;
//    - out-of-range read: returns rdata = 0 with rerr = 1 and normal latency.
//  - Not defined:
//    - array holds 2**ADDR_W words and DEPTH is ignored, so every address is valid;
//    - rerr is tied to 0; the sweep covers 2**ADDR_W words.
// TESTING
//  1. Reset, then write 0x2/0x3/0x4 to addr 1/2/3 and read addr 1..3 back-to-back with RD_LAT=2:
//     -> rvalid high for 3 consecutive cycles starting 2 cycles after the first read accept,
//        rdata 0x2, 0x3, 0x4, and rdata = 0 outside those cycles.
//  2. Write 0xA5 to addr 7, then read addr 7 in the very next cycle -> rdata = 0xA5.
//  3. Fill all words with 0xFF, pulse clr_start:
//     -> req_ready low for exactly DEPTH cycles, then one clr_done pulse;
//     -> reading any address returns 0x00.
//  4. clr_start with a read of addr 3 (holding 0x4) accepted the same cycle
//     -> read returns 0x4, and the sweep then starts.
//  5. Assert rst at sweep cycle 10 of 61:
//     -> no clr_done; words 0..9 read 0; word 10 and above keep their old data
//        (word 10 may be either 0 or old data, since its clear write coincides with the reset edge).
//  6. With DATA_MEM_BOUNDS_CHECK_EN and DEPTH=61:
//     -> write 0x55 to addr 62, then read addr 62 -> rdata = 0 with rerr = 1;
//     -> read addr 60 -> rerr = 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: parametrised single-port data memory with a valid/ready
// request port, a registered read pipeline of RD_LAT stages and a hardware
// clear sweep driven by a two-state FSM (IDLE / CLEAR).
//
// Optional feature macro: DATA_MEM_BOUNDS_CHECK_EN
//   defined   -> array holds DEPTH words, addresses >= DEPTH are out of range
//                (writes dropped, reads return 0 with rerr = 1)
//   undefined -> array holds 2**ADDR_W words, every address valid, rerr = 0
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both high; req_ready depends only on the FSM state and rst,
// never on req_valid. Reads answer with a one-cycle rvalid pulse RD_LAT
// cycles after the accept edge, in order; writes have no response.
module data_mem_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 61,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              dbg_state
);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  localparam int MEM_DEPTH = DEPTH;
`else
  localparam int MEM_DEPTH = 2 ** ADDR_W;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

  // Reject configurations the array and pipeline cannot represent.
  if (RD_LAT < 1 || RD_LAT > 4 || DEPTH < 1 || DEPTH > 2 ** ADDR_W) begin : g_param_err
    $error("data_mem_ctrl: illegal RD_LAT/DEPTH/ADDR_W combination");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                clr_done_q;

  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  logic [RD_LAT-1:0]   pv_q;
  logic [RD_LAT-1:0]   pe_q;
  logic [DATA_W-1:0]   pd_q [RD_LAT];

  logic                in_range;
  logic                acc;
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_W-1:0]   rd_data_d;
  logic                rd_err_d;

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
`else
  assign in_range = 1'b1;
`endif

  assign req_ready = (state_q == IDLE) & ~rst;
  assign acc       = req_valid & req_ready;
  assign wr_acc    = acc & req_we;
  assign rd_acc    = acc & ~req_we;

  // Data entering the read pipeline is already zeroed when there is no
  // valid read, so rdata is 0 whenever rvalid is 0 without an output mux.
  always_comb begin
    rd_data_d = '0;
    rd_err_d  = 1'b0;
    if (rd_acc) begin
      if (in_range) rd_data_d = mem_q[req_addr];
      else          rd_err_d  = 1'b1;
    end
  end

  // Control FSM: IDLE serves requests, CLEAR zeroes one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      clr_cnt_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt_q == LAST_IDX) begin
            state_q    <= IDLE;
            clr_done_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array write port: sweep writes in CLEAR, accepted writes in IDLE.
  // Contents are deliberately not reset; a reset edge suppresses the sweep write.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR && !rst) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_acc && in_range) begin
      mem_q[req_addr] <= req_wdata;
    end
  end

  // Read pipeline: stage 0 samples the array on the accept edge, later
  // stages only delay it, which keeps reads strictly in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) pd_q[i] <= '0;
    end else begin
      pv_q[0] <= rd_acc;
      pe_q[0] <= rd_err_d;
      pd_q[0] <= rd_data_d;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pe_q[i] <= pe_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign rvalid    = pv_q[RD_LAT-1];
  assign rdata     = pd_q[RD_LAT-1];
  assign rerr      = pe_q[RD_LAT-1];
  assign clr_done  = clr_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl with RD_LAT = 2: directed vectors, a driver that
// pushes expected read responses, and a monitor that pops them on rvalid.
module tb_data_mem_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 61;
  localparam int RD_LAT = 2;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
  localparam int MEM_DEPTH = DEPTH;
`else
  localparam int MEM_DEPTH = 2 ** ADDR_W;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              rerr;
  logic              clr_start;
  logic              clr_done;
  logic              dbg_state;

  data_mem_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rvalid(rvalid), .rdata(rdata), .rerr(rerr), .clr_start(clr_start),
    .clr_done(clr_done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              exp_err_q[$];
  int                exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int addr, input int data);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = ADDR_W'(addr);
    req_wdata = DATA_W'(data);
    check("wr_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_read(input int addr, input int exp_data, input bit exp_err);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = ADDR_W'(addr);
    check("rd_ready", 32'(req_ready), 32'd1);
    exp_q.push_back(DATA_W'(exp_data));
    exp_err_q.push_back(exp_err);
    exp_cyc_q.push_back(cyc + RD_LAT);
    tick();
    req_valid = 1'b0;
  endtask

  // Counts cycles with req_ready low (bounded) and checks clr_done timing.
  task automatic wait_clear(input string name);
    int n;
    bit early_done;
    n = 0;
    early_done = 1'b0;
    while (!req_ready && n < 200) begin
      if (clr_done) early_done = 1'b1;
      n++;
      tick();
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(MEM_DEPTH));
    check({name, "_early_done"}, 32'(early_done), 32'd0);
    check({name, "_done_pulse"}, 32'(clr_done), 32'd1);
    tick();
    check({name, "_done_single"}, 32'(clr_done), 32'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rdata 0x%0h, expected no response (cycle %0d)", rdata, cyc);
      end else begin
        check("rdata", 32'(rdata), 32'(exp_q.pop_front()));
        check("rerr", 32'(rerr), 32'(exp_err_q.pop_front()));
        check("rd_latency_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end else if (!rst) begin
      check("rdata_idle_zero", 32'(rdata), 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit saw_done;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    clr_start = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_clr_done", 32'(clr_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);
    tick();

    // T1: three writes, back-to-back reads, latency 2
    do_write(1, 8'h02);
    do_write(2, 8'h03);
    do_write(3, 8'h04);
    do_read(1, 8'h02, 1'b0);
    do_read(2, 8'h03, 1'b0);
    do_read(3, 8'h04, 1'b0);
    repeat (4) tick();

    // T2: read in the cycle right after a write to the same address
    do_write(7, 8'hA5);
    do_read(7, 8'hA5, 1'b0);
    // Boundary addresses and alternating patterns
    do_write(0, 8'h3C);
    do_write(MEM_DEPTH - 1, 8'hC3);
    do_read(0, 8'h3C, 1'b0);
    do_read(MEM_DEPTH - 1, 8'hC3, 1'b0);
    do_read(7, 8'hA5, 1'b0);
    repeat (4) tick();

    // T3: fill, clear sweep, everything reads zero
    for (int i = 0; i < MEM_DEPTH; i++) do_write(i, 8'hFF);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    check("clr_state", 32'(dbg_state), 32'd1);
    wait_clear("t3");
    do_read(0, 8'h00, 1'b0);
    do_read(1, 8'h00, 1'b0);
    do_read(30, 8'h00, 1'b0);
    do_read(MEM_DEPTH - 1, 8'h00, 1'b0);
    repeat (4) tick();

    // T4: read accepted in the same cycle as clr_start sees pre-clear data
    do_write(3, 8'h04);
    clr_start = 1'b1;
    do_read(3, 8'h04, 1'b0);
    clr_start = 1'b0;
    check("t4_sweep_started", 32'(req_ready), 32'd0);
    wait_clear("t4");
    do_read(3, 8'h00, 1'b0);
    repeat (4) tick();

    // T5: reset at sweep cycle 10 aborts the sweep
    for (int i = 0; i < 16; i++) do_write(i, 8'h10 + i);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < MEM_DEPTH + 8; i++) begin
      if (clr_done) saw_done = 1'b1;
      tick();
    end
    check("t5_no_clr_done", 32'(saw_done), 32'd0);
    check("t5_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 10; i++) do_read(i, 8'h00, 1'b0);
    for (int i = 11; i < 16; i++) do_read(i, 8'h10 + i, 1'b0);
    repeat (4) tick();

    // T6: address 62 / 60 behaviour depends on the bounds-check build
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    do_write(62, 8'h55);
    do_read(62, 8'h00, 1'b1);
    do_read(60, 8'h00, 1'b0);
`else
    do_write(62, 8'h55);
    do_read(62, 8'h55, 1'b0);
    do_read(60, 8'h00, 1'b0);
`endif

    // Drain outstanding reads with a bound
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("pending_reads", 32'(exp_q.size()), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
